// File: rtl/prog_loader.sv
// Byte-serial program loader and 16-word instruction store for the mips16 core.
// Packs byte pairs big-endian into words and holds the core in reset while loading.
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [15:0]   fetch_addr,
    output logic [15:0]   instruction,
    output logic          cpu_rst,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic [7:0]    checksum
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        RUN
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  hi;
    logic [15:0] mem [DEPTH];
    logic        load_en_q;
    logic        accept;
    logic        last_word;
    logic        in_range;
    logic        unused_ok;

    assign accept    = byte_valid && byte_ready;
    assign last_word = (word_count == (AW+1)'(DEPTH - 1));

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        unique case (state)
            IDLE: begin
                next_state = load_en ? WAIT_HI : RUN;
            end
            WAIT_HI: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    next_state = WAIT_LO;
                else if (!load_en)
                    next_state = RUN;
            end
            WAIT_LO: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    next_state = last_word ? RUN : WAIT_HI;
                else if (!load_en)
                    next_state = RUN;
            end
            RUN: begin
                if (load_en && !load_en_q)
                    next_state = WAIT_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
            hi         <= '0;
            load_en_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state     <= next_state;
            cpu_rst   <= (next_state != RUN);
            load_en_q <= load_en;
            load_done <= (state == WAIT_LO) && accept && last_word;
            if (state == RUN && next_state == WAIT_HI) begin
                word_count <= '0;
                checksum   <= '0;
            end
            if (state == WAIT_HI && accept) begin
                hi       <= byte_in;
                checksum <= checksum ^ byte_in;
            end
            if (state == WAIT_LO && accept) begin
                mem[word_count[AW-1:0]] <= {hi, byte_in};
                checksum   <= checksum ^ byte_in;
                word_count <= word_count + 1'b1;
            end
        end
    end

    // Byte address: bit 0 selects a byte within the word and is irrelevant here
    assign in_range    = (fetch_addr[15:AW+1] == '0);
    assign instruction = in_range ? mem[fetch_addr[AW:1]] : 16'h0000;
    assign unused_ok   = fetch_addr[0];

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-serial instruction loader and instruction store sitting directly upstream of the mips16 single-cycle core; it replaces the fixed instruction ROM.
- Accepts a program as bytes from the Tiny Tapeout input pins via a valid/ready handshake and packs byte pairs into 16-bit instruction words.
- Holds the core in reset while loading, then serves combinational instruction fetches from the core's PC byte address.

Parameters:
- DEPTH, 16, number of 16-bit instruction words stored.
- AW, 4, word-index width, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_en  input  1  load-mode request, level-sensitive; already synchronised at top level.
- byte_in  input  8  program byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- fetch_addr  input  16  PC byte address from the core.
- instruction  output  16  instruction word to the core's decoder.
- cpu_rst  output  1  registered reset to the core, active-high.
- load_done  output  1  one-cycle pulse when a complete DEPTH-word load commits.
- word_count  output  AW+1  number of words committed in the current or last load, 0..DEPTH.
- checksum  output  8  XOR of all bytes accepted in the current or last load.

Behaviour:
- States: IDLE, WAIT_HI, WAIT_LO, RUN. The block is a 2-bit FSM with a word pointer, a hi-byte holding register, and a DEPTH x 16 register array.
- Reset (async): state=IDLE, cpu_rst=1, byte_ready=0, load_done=0, word_count=0, checksum=0, hi register=0, all memory words=0, load_en_q=0.
- Accept rule: a byte is accepted on an edge where byte_valid && byte_ready. byte_ready = 1 only in WAIT_HI/WAIT_LO, combinational from state. byte_valid is ignored in IDLE and RUN.
- IDLE:
  - load_en=1 -> WAIT_HI.
  - else -> RUN.
- WAIT_HI:
  - On accept: hi<=byte_in; checksum^=byte_in; -> WAIT_LO.
  - load_en=0 with no accept -> RUN (abort).
- WAIT_LO:
  - On accept: mem[word_count]<={hi,byte_in}, big-endian with the first byte in [15:8]; checksum^=byte_in; word_count+=1.
  - If that word is the DEPTH-th word: load_done=1 for exactly that cycle; -> RUN. Otherwise -> WAIT_HI.
  - load_en=0 with no accept -> RUN. The held hi byte is discarded, but checksum keeps its contribution.
  - Same-edge accept and load_en=0: the accept wins, the word is committed, then -> RUN next evaluation.
- RUN:
  - load_en rising edge (load_en=1 && load_en_q=0) -> WAIT_HI; word_count<=0, checksum<=0.
  - A level-high load_en after a completed load does not restart loading.
  - Memory words not rewritten by an aborted or partial load keep their old contents.
- load_en_q registers load_en every cycle.
- cpu_rst is a register loaded with (next_state != RUN). It falls on the same edge the FSM enters RUN and rises on the same edge RUN exits.
- Fetch (combinational, all states):
  - instruction = mem[fetch_addr[AW:1]] when fetch_addr[15:AW+1]==0; otherwise 16'h0000.
  - fetch_addr[0] is ignored.
- Writes are synchronous only. Read-during-write of the same word returns the old value until the edge.
- Reset mid-load: everything returns to reset values immediately, independent of clk.

Test Plan:
- Reset then release with load_en=0 -> cycle 1 in IDLE with cpu_rst=1, byte_ready=0. Next edge enters RUN, cpu_rst=0, instruction=0000 for all fetch_addr.
- load_en=1, stream bytes 00 01, 12 34 … then 50 00 (32 bytes, DEPTH words) -> load_done pulses once on the 32nd accept, word_count=16, cpu_rst falls the same edge. fetch_addr=0 gives 0001, fetch_addr=2 gives 1234, fetch_addr=30 gives 5000, fetch_addr=32 gives 0000. checksum equals the XOR of all 32 bytes.
- Partial load: after the full load, pulse load_en 0->1, send AA BB CC, drop load_en -> RUN with word_count=1. mem[0]=AABB, mem[1] unchanged; checksum=AA^BB^CC=DD. byte_ready=0 while byte_valid is held high in RUN.
- byte_valid toggled 1-0-1 with gaps in WAIT_HI/WAIT_LO -> only cycles with valid=1 advance the FSM. Holding load_en high after load_done does not restart loading.
- Assert rst after 5 accepted bytes -> all outputs return to reset values asynchronously and memory reads 0000. Release with load_en=1 -> loading restarts at word 0.
- Same-edge final byte accept and load_en fall in WAIT_LO -> the word is committed, word_count is incremented, and the FSM goes to RUN with no extra word.
